// File: rtl/zov5640_pkg.sv
// Shared definitions for the OV5640 bring-up sequencer: SCCB op codes,
// table markers, ID register addresses, error codes and FSM states.
package zov5640_pkg;

  localparam logic [2:0] OP_HWRST = 3'b000;
  localparam logic [2:0] OP_RD    = 3'b001;
  localparam logic [2:0] OP_WR    = 3'b010;
  localparam logic [2:0] OP_PARK  = 3'b011;

  localparam logic [15:0] TBL_END  = 16'hFFFF;
  localparam logic [15:0] TBL_DLY  = 16'hFFFE;
  localparam logic [15:0] REG_ID_H = 16'h300A;
  localparam logic [15:0] REG_ID_L = 16'h300B;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ID   = 2'd1;
  localparam logic [1:0] ERR_TO   = 2'd2;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } tbl_entry_t;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_PARK_INIT = 4'd1,
    ST_HWRST     = 4'd2,
    ST_RD_IDH    = 4'd3,
    ST_RD_IDL    = 4'd4,
    ST_CHK       = 4'd5,
    ST_FETCH     = 4'd6,
    ST_DEC       = 4'd7,
    ST_WR        = 4'd8,
    ST_DELAY     = 4'd9,
    ST_TO_PARK   = 4'd10,
    ST_END       = 4'd11,
    ST_ERR       = 4'd12
  } seq_state_e;

endpackage

// File: rtl/zov5640_op_timer.sv
// Loadable down-counter shared by the per-op timeout and table delays;
// expired is high while the count sits at zero.
module zov5640_op_timer #(
  parameter int W = 32
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt_r;

  // count register: load wins, otherwise decrement down to zero
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= value;
    end else if (en && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == '0);

endmodule

// File: rtl/zov5640_init_seq.sv
// OV5640 bring-up sequencer: hardware reset, chip-ID check, then a walk
// through an external register-write ROM, all via the SCCB engine.
module zov5640_init_seq
  import zov5640_pkg::*;
#(
  parameter int          TBL_AW         = 9,
  parameter logic [15:0] CHIP_ID        = 16'h5640,
  parameter int          TIMEOUT_CYC    = 262143,
  parameter int          DELAY_UNIT_CYC = 100000
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  output logic [TBL_AW-1:0] oTblAddr,
  input  logic [23:0]       iTblData,
  output logic              oSccbEn,
  output logic [2:0]        oOpReq,
  output logic [15:0]       oRegAddr,
  output logic [7:0]        oWrData,
  input  logic [7:0]        iRdData,
  input  logic              iOpDone,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr,
  output logic [1:0]        oErrCode,
  output logic [15:0]       oChipId,
  output logic [TBL_AW-1:0] oWrCount
);

  localparam int TMR_W = 32;

  seq_state_e        state_r, state_nxt_s;
  logic [2:0]        op_r, op_nxt_s;
  logic              en_r, en_nxt_s;
  logic [15:0]       addr_r, addr_nxt_s;
  logic [7:0]        wd_r, wd_nxt_s;
  logic [TBL_AW-1:0] tbl_addr_r, tbl_nxt_s;
  logic [TBL_AW-1:0] wrcnt_r, wrcnt_nxt_s;
  logic              done_r, done_nxt_s;
  logic              err_r, err_nxt_s;
  logic [1:0]        code_r, code_nxt_s;
  logic [15:0]       chip_r, chip_nxt_s;
  logic              park_pend_r, park_nxt_s;
  logic              busy_r;

  logic              adv_s;
  logic              op_fin_s;
  logic              in_op_s;
  logic              tbl_last_s;
  logic              tmr_load_s;
  logic [TMR_W-1:0]  tmr_val_s;
  logic              tmr_en_s;
  logic              tmr_exp_s;
  tbl_entry_t        entry_s;

  assign entry_s    = tbl_entry_t'(iTblData);
  assign op_fin_s   = en_r & iOpDone;
  assign tbl_last_s = &tbl_addr_r;
  assign in_op_s    = (state_r == ST_HWRST) || (state_r == ST_RD_IDH) ||
                      (state_r == ST_RD_IDL) || (state_r == ST_WR);
  assign tmr_en_s   = (state_r != ST_IDLE);

  zov5640_op_timer #(.W(TMR_W)) u_timer (
    .iClk    (iClk),
    .iRst    (iRst),
    .load    (tmr_load_s),
    .value   (tmr_val_s),
    .en      (tmr_en_s),
    .expired (tmr_exp_s)
  );

  // next-state and next-output decode
  always_comb begin
    state_nxt_s = state_r;
    op_nxt_s    = op_r;
    en_nxt_s    = en_r;
    addr_nxt_s  = addr_r;
    wd_nxt_s    = wd_r;
    tbl_nxt_s   = tbl_addr_r;
    wrcnt_nxt_s = wrcnt_r;
    done_nxt_s  = done_r;
    err_nxt_s   = err_r;
    code_nxt_s  = code_r;
    chip_nxt_s  = chip_r;
    park_nxt_s  = park_pend_r;
    adv_s       = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_val_s   = '0;

    case (state_r)
      ST_IDLE: begin
        if (iStart) begin
          done_nxt_s  = 1'b0;
          err_nxt_s   = 1'b0;
          code_nxt_s  = ERR_NONE;
          wrcnt_nxt_s = '0;
          tbl_nxt_s   = '0;
          // after our own reset the engine may be mid-op, so park it first
          if (park_pend_r) begin
            state_nxt_s = ST_PARK_INIT;
            op_nxt_s    = OP_PARK;
            en_nxt_s    = 1'b1;
          end else begin
            state_nxt_s = ST_HWRST;
            op_nxt_s    = OP_HWRST;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PARK_INIT: begin
        en_nxt_s    = 1'b0;
        park_nxt_s  = 1'b0;
        op_nxt_s    = OP_HWRST;
        state_nxt_s = ST_HWRST;
      end
      ST_HWRST: begin
        if (op_fin_s) begin
          state_nxt_s = ST_RD_IDH;
          op_nxt_s    = OP_RD;
          addr_nxt_s  = REG_ID_H;
        end else begin
          state_nxt_s = ST_HWRST;
        end
      end
      ST_RD_IDH: begin
        if (op_fin_s) begin
          chip_nxt_s[15:8] = iRdData;
          state_nxt_s      = ST_RD_IDL;
          addr_nxt_s       = REG_ID_L;
        end else begin
          state_nxt_s = ST_RD_IDH;
        end
      end
      ST_RD_IDL: begin
        if (op_fin_s) begin
          chip_nxt_s[7:0] = iRdData;
          state_nxt_s     = ST_CHK;
        end else begin
          state_nxt_s = ST_RD_IDL;
        end
      end
      ST_CHK: begin
        if (chip_r == CHIP_ID) begin
          state_nxt_s = ST_FETCH;
          tbl_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_ERR;
          code_nxt_s  = ERR_ID;
        end
      end
      ST_FETCH: begin
        state_nxt_s = ST_DEC;
      end
      ST_DEC: begin
        if (entry_s.addr == TBL_END) begin
          state_nxt_s = ST_END;
        end else if (entry_s.addr == TBL_DLY) begin
          if (entry_s.data == 8'd0) begin
            adv_s = 1'b1;
          end else begin
            // load one short: the DELAY state itself spends the final cycle at zero
            state_nxt_s = ST_DELAY;
            tmr_load_s  = 1'b1;
            tmr_val_s   = TMR_W'(entry_s.data) * TMR_W'(DELAY_UNIT_CYC) - TMR_W'(1);
          end
        end else begin
          state_nxt_s = ST_WR;
          op_nxt_s    = OP_WR;
          addr_nxt_s  = entry_s.addr;
          wd_nxt_s    = entry_s.data;
        end
      end
      ST_WR: begin
        if (op_fin_s) begin
          wrcnt_nxt_s = wrcnt_r + TBL_AW'(1);
          adv_s       = 1'b1;
        end else begin
          state_nxt_s = ST_WR;
        end
      end
      ST_DELAY: begin
        if (tmr_exp_s) begin
          adv_s = 1'b1;
        end else begin
          state_nxt_s = ST_DELAY;
        end
      end
      ST_TO_PARK: begin
        en_nxt_s    = 1'b0;
        code_nxt_s  = ERR_TO;
        state_nxt_s = ST_ERR;
      end
      ST_END: begin
        done_nxt_s  = 1'b1;
        op_nxt_s    = OP_PARK;
        state_nxt_s = ST_IDLE;
      end
      ST_ERR: begin
        err_nxt_s   = 1'b1;
        op_nxt_s    = OP_PARK;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        en_nxt_s    = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase

    // last table slot behaves as if END followed it; the address never wraps
    if (adv_s) begin
      if (tbl_last_s) begin
        state_nxt_s = ST_END;
      end else begin
        tbl_nxt_s   = tbl_addr_r + TBL_AW'(1);
        state_nxt_s = ST_FETCH;
      end
    end else begin
      tbl_nxt_s = tbl_nxt_s;
    end

    // shared handshake for every op state: setup cycle, then hold until done or timeout
    if (in_op_s) begin
      if (!en_r) begin
        en_nxt_s   = 1'b1;
        tmr_load_s = 1'b1;
        tmr_val_s  = TMR_W'(TIMEOUT_CYC) - TMR_W'(1);
      end else if (iOpDone) begin
        en_nxt_s = 1'b0;
      end else if (tmr_exp_s) begin
        en_nxt_s    = 1'b1;
        op_nxt_s    = OP_PARK;
        state_nxt_s = ST_TO_PARK;
      end else begin
        en_nxt_s = 1'b1;
      end
    end else begin
      en_nxt_s = en_nxt_s;
    end
  end

  // state and output registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_PARK;
      en_r        <= 1'b0;
      addr_r      <= 16'h0000;
      wd_r        <= 8'h00;
      tbl_addr_r  <= '0;
      wrcnt_r     <= '0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      code_r      <= ERR_NONE;
      chip_r      <= 16'h0000;
      park_pend_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      op_r        <= op_nxt_s;
      en_r        <= en_nxt_s;
      addr_r      <= addr_nxt_s;
      wd_r        <= wd_nxt_s;
      tbl_addr_r  <= tbl_nxt_s;
      wrcnt_r     <= wrcnt_nxt_s;
      done_r      <= done_nxt_s;
      err_r       <= err_nxt_s;
      code_r      <= code_nxt_s;
      chip_r      <= chip_nxt_s;
      park_pend_r <= park_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign oTblAddr = tbl_addr_r;
  assign oSccbEn  = en_r;
  assign oOpReq   = op_r;
  assign oRegAddr = addr_r;
  assign oWrData  = wd_r;
  assign oBusy    = busy_r;
  assign oDone    = done_r;
  assign oErr     = err_r;
  assign oErrCode = code_r;
  assign oChipId  = chip_r;
  assign oWrCount = wrcnt_r;

endmodule

// File: tb/tb_zov5640_init_seq.sv
// Directed bench for zov5640_init_seq with a behavioural SCCB engine and ROM.
module tb_zov5640_init_seq;

  localparam int AW   = 4;
  localparam int TO   = 200;
  localparam int UNIT = 10;
  localparam int LAT  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] tbl_addr;
  logic [23:0]   tbl_data;
  logic          sccb_en;
  logic [2:0]    op_req;
  logic [15:0]   reg_addr;
  logic [7:0]    wr_data;
  logic [7:0]    rd_data = 8'h00;
  logic          op_done = 1'b0;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic [15:0]   chip_id;
  logic [AW-1:0] wr_count;

  logic [23:0] rom [16];
  logic [2:0]  log_op   [32];
  logic [15:0] log_addr [32];
  logic [7:0]  log_dat  [32];
  int          log_gap  [32];
  int          n_log = 0, park_cyc = 0, wr_hi = 0, low_run = 0;
  int          eng_cnt = 0;
  bit          eng_busy = 1'b0, en_prev = 1'b0, hang_wr = 1'b0;
  logic [7:0]  id_h = 8'h56, id_l = 8'h40;
  int          n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  zov5640_init_seq #(
    .TBL_AW(AW), .CHIP_ID(16'h5640), .TIMEOUT_CYC(TO), .DELAY_UNIT_CYC(UNIT)
  ) dut (
    .iClk(clk), .iRst(rst), .iStart(start),
    .oTblAddr(tbl_addr), .iTblData(tbl_data),
    .oSccbEn(sccb_en), .oOpReq(op_req), .oRegAddr(reg_addr), .oWrData(wr_data),
    .iRdData(rd_data), .iOpDone(op_done),
    .oBusy(busy), .oDone(done), .oErr(err), .oErrCode(err_code),
    .oChipId(chip_id), .oWrCount(wr_count)
  );

  // synchronous table ROM, one cycle latency
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // engine model on the falling edge: logs op launches, answers after LAT cycles
  always @(negedge clk) begin
    op_done = 1'b0;
    if (sccb_en && op_req == 3'b011) park_cyc++;
    if (sccb_en && op_req == 3'b010) wr_hi++;
    if (!sccb_en) low_run++;
    if (sccb_en && !en_prev) begin
      if (n_log < 32) begin
        log_op[n_log]   = op_req;
        log_addr[n_log] = reg_addr;
        log_dat[n_log]  = wr_data;
        log_gap[n_log]  = low_run;
        n_log++;
      end
      if (op_req != 3'b011) begin
        eng_busy = 1'b1;
        eng_cnt  = LAT;
      end
    end else if (!sccb_en) begin
      eng_busy = 1'b0;
    end else if (eng_busy && !(hang_wr && op_req == 3'b010)) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        op_done  = 1'b1;
        eng_busy = 1'b0;
        rd_data  = (reg_addr == 16'h300A) ? id_h : (reg_addr == 16'h300B) ? id_l : 8'h00;
      end
    end
    if (sccb_en) low_run = 0;
    en_prev = sccb_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " err"}, err, 0);
    chk({tag, " code"}, err_code, 0);
    chk({tag, " opreq"}, op_req, 3'b011);
    chk({tag, " en"}, sccb_en, 0);
    chk({tag, " chipid"}, chip_id, 0);
    chk({tag, " wrcnt"}, wr_count, 0);
    chk({tag, " tbladdr"}, tbl_addr, 0);
  endtask

  task automatic clear_log();
    n_log = 0; park_cyc = 0; wr_hi = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    chk({tag, " finish-wait"}, busy, 0);
  endtask

  task automatic wait_log(input string tag, input int n);
    for (int i = 0; i < 500 && n_log < n; i++) @(negedge clk);
    chk({tag, " op-wait"}, (n_log >= n), 1);
  endtask

  task automatic std_rom();
    for (int i = 0; i < 16; i++) rom[i] = 24'hFFFF00;
    rom[0] = 24'h300808;
    rom[1] = 24'h310301;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    std_rom();
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;

    // 1: full bring-up, first start after reset is preceded by a PARK launch
    clear_log(); pulse_start(); wait_idle("t1");
    chk("t1 nops", n_log, 6);
    chk("t1 park", log_op[0], 3'b011);
    chk("t1 hwrst", log_op[1], 3'b000);
    chk("t1 rdh", {log_op[2], log_addr[2]}, {3'b001, 16'h300A});
    chk("t1 rdl", {log_op[3], log_addr[3]}, {3'b001, 16'h300B});
    chk("t1 wr0", {log_op[4], log_addr[4], log_dat[4]}, {3'b010, 16'h3008, 8'h08});
    chk("t1 wr1", {log_op[5], log_addr[5], log_dat[5]}, {3'b010, 16'h3103, 8'h01});
    chk("t1 gap", log_gap[5], 3);  // FETCH, DEC, setup
    chk("t1 parkcyc", park_cyc, 1);
    chk("t1 done", done, 1);
    chk("t1 err", err, 0);
    chk("t1 wrcnt", wr_count, 2);
    chk("t1 chipid", chip_id, 16'h5640);

    // 2: ID mismatch, no writes
    id_l = 8'h41;
    clear_log(); pulse_start(); wait_idle("t2");
    chk("t2 nops", n_log, 3);
    chk("t2 hwrst", log_op[0], 3'b000);
    chk("t2 err", err, 1);
    chk("t2 code", err_code, 1);
    chk("t2 done", done, 0);
    chk("t2 wrcnt", wr_count, 0);
    chk("t2 chipid", chip_id, 16'h5641);
    id_l = 8'h40;

    // 3: engine hangs on the first write
    hang_wr = 1'b1;
    clear_log(); pulse_start(); wait_idle("t3");
    chk("t3 nops", n_log, 4);
    chk("t3 wrhold", wr_hi, TO);
    chk("t3 parkcyc", park_cyc, 1);
    chk("t3 err", err, 1);
    chk("t3 code", err_code, 2);
    chk("t3 done", done, 0);
    chk("t3 en", sccb_en, 0);
    chk("t3 wrcnt", wr_count, 0);
    hang_wr = 1'b0;

    // 4: 5-unit delay then a zero delay between writes
    for (int i = 0; i < 16; i++) rom[i] = 24'hFFFF00;
    rom[0] = 24'h300808; rom[1] = 24'hFFFE05; rom[2] = 24'h310301;
    rom[3] = 24'hFFFE00; rom[4] = 24'h420177;
    clear_log(); pulse_start(); wait_idle("t4");
    chk("t4 nops", n_log, 6);
    chk("t4 gap5", log_gap[4], 5 * UNIT + 5);  // 50 delay + FETCH/DEC twice + setup
    chk("t4 gap0", log_gap[5], 5);
    chk("t4 wr2", {log_op[5], log_addr[5], log_dat[5]}, {3'b010, 16'h4201, 8'h77});
    chk("t4 wrcnt", wr_count, 3);
    chk("t4 done", done, 1);

    // 5: iStart during a write is ignored; reset mid RD_IDL; restart parks first
    std_rom();
    clear_log(); pulse_start(); wait_log("t5a", 4);
    pulse_start(); wait_idle("t5a");
    chk("t5 nops", n_log, 5);
    chk("t5 wrcnt", wr_count, 2);
    chk("t5 done", done, 1);
    clear_log(); pulse_start(); wait_log("t5b", 3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_reset("t5 midrst");
    rst = 1'b0;
    clear_log(); pulse_start(); wait_idle("t5c");
    chk("t5 park", log_op[0], 3'b011);
    chk("t5 hwrst", log_op[1], 3'b000);
    chk("t5 parkcyc", park_cyc, 1);
    chk("t5 done2", done, 1);
    chk("t5 wrcnt2", wr_count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
